// File: rtl/mixcol_engine_if.sv
// Handshake bundle for the MixColumns engine: upstream beat in, transformed beat out.
interface mixcol_engine_if #(
    parameter int NCOL = 4
);
    localparam int W = 32 * NCOL;

    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_mode;
    logic         out_err;

    // Producer of input beats and consumer of output beats
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_err
    );

    // The engine itself
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_err
    );
endinterface

// File: rtl/mixcol_engine.sv
// Pipelined AES MixColumns / InvMixColumns / bypass datapath, NCOL columns per beat.
// All GF(2^8) logic sits in front of stage 1; later stages are plain delay registers.
module mixcol_engine #(
    parameter int NCOL = 4,
    parameter int PIPE = 2
) (
    input  logic           clk,
    input  logic           rst,
    mixcol_engine_if.slave bus
);
    localparam int W = 32 * NCOL;

    typedef enum logic [1:0] {
        MODE_FWD = 2'b00,
        MODE_INV = 2'b01,
        MODE_BYP = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // One output row of the forward matrix: 2*a ^ 3*b ^ c ^ d
    function automatic logic [7:0] fwd_row(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        return xtime(a) ^ xtime(b) ^ b ^ c ^ d;
    endfunction

    // One output row of the inverse matrix: 14*a ^ 11*b ^ 13*c ^ 9*d
    function automatic logic [7:0] inv_row(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        logic [7:0] a2, a4, a8, b2, b8, c4, c8, d8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        b2 = xtime(b);
        b8 = xtime(xtime(b2));
        c4 = xtime(xtime(c));
        c8 = xtime(c4);
        d8 = xtime(xtime(xtime(d)));
        return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
    endfunction

    // Rows are the same row function applied to rotated copies of the column
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {fwd_row(a0, a1, a2, a3), fwd_row(a1, a2, a3, a0),
                fwd_row(a2, a3, a0, a1), fwd_row(a3, a0, a1, a2)};
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
                inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};
    endfunction

    logic         en;
    logic [W-1:0] fwd_data;
    logic [W-1:0] inv_data;
    logic [W-1:0] s1_data;
    logic         s1_err;

    logic [W-1:0] st_data [PIPE];
    logic [1:0]   st_mode [PIPE];
    logic         st_err  [PIPE];
    logic         st_vld  [PIPE];

    assign en           = !st_vld[PIPE-1] | bus.out_ready;
    assign bus.in_ready = en & !rst;

    // Columns are independent: one forward and one inverse unit per column
    for (genvar gc = 0; gc < NCOL; gc++) begin : g_col
        assign fwd_data[W-1-32*gc -: 32] = mix_fwd(bus.in_data[W-1-32*gc -: 32]);
        assign inv_data[W-1-32*gc -: 32] = mix_inv(bus.in_data[W-1-32*gc -: 32]);
    end

    // Select the transform for this beat; reserved mode passes through and is flagged
    always_comb begin
        s1_data = bus.in_data;
        case (mode_e'(bus.in_mode))
            MODE_FWD: s1_data = fwd_data;
            MODE_INV: s1_data = inv_data;
            default:  s1_data = bus.in_data;
        endcase
        s1_err = (mode_e'(bus.in_mode) == MODE_RSV);
    end

    // Lock-step pipeline: every stage advances together whenever the output can move
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < PIPE; s++) begin
                st_vld[s]  <= 1'b0;
                st_data[s] <= '0;
                st_mode[s] <= 2'b00;
                st_err[s]  <= 1'b0;
            end
        end else if (en) begin
            st_vld[0]  <= bus.in_valid & bus.in_ready;
            st_data[0] <= s1_data;
            st_mode[0] <= bus.in_mode;
            st_err[0]  <= s1_err;
            for (int unsigned s = 1; s < PIPE; s++) begin
                st_vld[s]  <= st_vld[s-1];
                st_data[s] <= st_data[s-1];
                st_mode[s] <= st_mode[s-1];
                st_err[s]  <= st_err[s-1];
            end
        end
    end

    assign bus.out_valid = st_vld[PIPE-1];
    assign bus.out_data  = st_data[PIPE-1];
    assign bus.out_mode  = st_mode[PIPE-1];
    assign bus.out_err   = st_err[PIPE-1];

endmodule

// File: tb/tb_mixcol_engine.sv
// Bench for mixcol_engine: main NCOL=4/PIPE=2 instance with a model scoreboard,
// plus a sweep of other NCOL/PIPE combinations driven one beat at a time.
module tb_mixcol_engine;

    localparam int MP = 2;
    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply by shift-and-add, reducing by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        int p = 0;
        int x = int'(a);
        for (int i = 0; i < 4; i++) begin
            if ((b & (1 << i)) != 0) p = p ^ x;
            x = x * 2;
            if (x > 255) x = x ^ 'h11B;
        end
        return 8'(p);
    endfunction

    // Matrix-times-column for each column; modes 2/3 are identity
    function automatic logic [255:0] model(input logic [255:0] d, input int nc, input logic [1:0] md);
        int coef [4];
        logic [255:0] r = d;
        logic [7:0] acc;
        if (md > 2'd1) return d;
        if (md == 2'd0) coef = '{2, 3, 1, 1};
        else            coef = '{14, 11, 13, 9};
        for (int c = 0; c < nc; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(d[32*(nc-1-c) + 8*(3-((i+j)%4)) +: 8], coef[j]);
                r[32*(nc-1-c) + 8*(3-i) +: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [255:0] rep(input logic [31:0] col, input int nc);
        logic [255:0] r = '0;
        for (int c = 0; c < nc; c++) r[32*c +: 32] = col;
        return r;
    endfunction

    // ---------------- main instance ----------------
    logic m_rst;
    mixcol_engine_if #(.NCOL(4)) m_if ();
    mixcol_engine #(.NCOL(4), .PIPE(MP)) u_dut (.clk(clk), .rst(m_rst), .bus(m_if));

    typedef struct {
        logic [255:0] d;
        logic [1:0]   m;
        logic         e;
        int           acc;
    } beat_t;

    beat_t mq[$];
    beat_t dq[$];
    int    deliv = 0;
    bit    lat_chk = 1'b1;

    // Scoreboard: every cycle check handshake rules, stall stability and delivered beats
    initial begin
        beat_t b;
        bit stall = 1'b0;
        logic [127:0] h_d;
        logic [1:0] h_m;
        logic h_e;
        forever begin
            @(negedge clk);
            #2;
            if (m_rst) begin
                chk("rdy_in_rst", 256'(m_if.in_ready), 256'(0));
                mq.delete();
                dq.delete();
                stall = 1'b0;
            end else begin
                chk("rdy_en", 256'(m_if.in_ready), 256'(!m_if.out_valid | m_if.out_ready));
                if (stall) begin
                    chk("hold_vld", 256'(m_if.out_valid), 256'(1));
                    chk("hold_dat", 256'(m_if.out_data), 256'(h_d));
                    chk("hold_mode", 256'(m_if.out_mode), 256'(h_m));
                    chk("hold_err", 256'(m_if.out_err), 256'(h_e));
                end
                if (m_if.out_valid && m_if.out_ready) begin
                    deliv++;
                    chk("beat_expected", 256'(mq.size() > 0), 256'(1));
                    if (mq.size() > 0) begin
                        b = mq.pop_front();
                        chk("dat", 256'(m_if.out_data), b.d);
                        chk("mode", 256'(m_if.out_mode), 256'(b.m));
                        chk("err", 256'(m_if.out_err), 256'(b.e));
                        if (lat_chk) chk("lat", 256'(cyc - b.acc), 256'(MP));
                    end
                    if (dq.size() > 0) begin
                        b = dq.pop_front();
                        chk("dir_dat", 256'(m_if.out_data), b.d);
                        chk("dir_err", 256'(m_if.out_err), 256'(b.e));
                    end
                end
                if (m_if.in_valid && m_if.in_ready)
                    mq.push_back('{model(256'(m_if.in_data), 4, m_if.in_mode),
                                   m_if.in_mode, m_if.in_mode == 2'b11, cyc});
                stall = m_if.out_valid && !m_if.out_ready;
                h_d = m_if.out_data;
                h_m = m_if.out_mode;
                h_e = m_if.out_err;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the beat was accepted
    task automatic m_send(input logic [127:0] d, input logic [1:0] md, output int acc);
        int n = 0;
        m_if.in_valid = 1'b1;
        m_if.in_data  = d;
        m_if.in_mode  = md;
        #2;
        while (!m_if.in_ready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("send_timeout", 256'(n < 200), 256'(1));
        acc = cyc;
        @(negedge clk);
        m_if.in_valid = 1'b0;
    endtask

    task automatic m_dir(input logic [127:0] d, input logic [1:0] md, input logic [127:0] exp);
        int acc;
        dq.push_back('{256'(exp), md, md == 2'b11, 0});
        m_send(d, md, acc);
    endtask

    task automatic m_drain();
        int n = 0;
        while ((mq.size() != 0 || m_if.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 256'(n < 200), 256'(1));
        @(negedge clk);
    endtask

    // ---------------- parameter sweep instances ----------------
    logic [31:0] vin  [6] = '{32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6,
                              32'hd4d4d4d5, 32'h2d26314c, 32'h8e4da1bc};
    logic [31:0] vout [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6,
                              32'hd5d5d7d6, 32'h4d7ebdf8, 32'hdb135345};
    logic [1:0]  vmd  [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int NC = (g % 2 == 0) ? 1 : 8;
        localparam int PP = (g == 0 || g == 3) ? 1 : 4;
        logic s_rst;
        bit   done = 1'b0;
        mixcol_engine_if #(.NCOL(NC)) s_if ();
        mixcol_engine #(.NCOL(NC), .PIPE(PP)) u_dut (.clk(clk), .rst(s_rst), .bus(s_if));

        // One beat at a time: check exact latency and every column
        initial begin
            logic [255:0] d, e;
            logic [1:0] md;
            int acc, n;
            s_rst = 1'b1;
            s_if.in_valid  = 1'b0;
            s_if.in_data   = '0;
            s_if.in_mode   = 2'b00;
            s_if.out_ready = 1'b1;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            for (int k = 0; k < 12; k++) begin
                if (k < 6) begin
                    md = vmd[k];
                    d  = rep(vin[k], NC);
                    e  = rep(vout[k], NC);
                end else begin
                    d  = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
                    d  = d >> (256 - 32 * NC);
                    md = 2'($urandom_range(0, 3));
                    e  = model(d, NC, md);
                end
                @(negedge clk);
                s_if.in_valid = 1'b1;
                s_if.in_data  = d[32*NC-1:0];
                s_if.in_mode  = md;
                #2;
                chk($sformatf("sw%0d_rdy", g), 256'(s_if.in_ready), 256'(1));
                acc = cyc;
                @(negedge clk);
                s_if.in_valid = 1'b0;
                n = 0;
                #2;
                while (!s_if.out_valid && n < 20) begin
                    @(negedge clk);
                    #2;
                    n++;
                end
                chk($sformatf("sw%0d_lat%0d", g, k), 256'(cyc - acc), 256'(PP));
                chk($sformatf("sw%0d_dat%0d", g, k), 256'(s_if.out_data), e);
                chk($sformatf("sw%0d_err%0d", g, k), 256'(s_if.out_err), 256'(md == 2'b11));
            end
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc, first, last, d0, n;
        logic [127:0] r1, r2;
        m_rst = 1'b1;
        m_if.in_valid  = 1'b0;
        m_if.in_data   = '0;
        m_if.in_mode   = 2'b00;
        m_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_vld", 256'(m_if.out_valid), 256'(0));
        chk("rst_dat", 256'(m_if.out_data), 256'(0));
        chk("rst_mode", 256'(m_if.out_mode), 256'(0));
        chk("rst_err", 256'(m_if.out_err), 256'(0));
        @(negedge clk);
        m_rst = 1'b0;

        // Directed forward / inverse vectors
        m_dir(FIPS_IN, 2'b00, FIPS_OUT);
        m_drain();
        m_dir(FIPS_OUT, 2'b01, FIPS_IN);
        m_drain();
        m_dir(128'(rep(32'h8e4da1bc, 4)), 2'b01, 128'(rep(32'hdb135345, 4)));
        m_drain();

        // Mixed modes back to back
        r1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        r2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_dir(FIPS_IN, 2'b00, FIPS_OUT);
        m_dir(FIPS_OUT, 2'b01, FIPS_IN);
        m_dir(r1, 2'b10, r1);
        m_dir(r2, 2'b11, r2);
        m_drain();

        // Full-rate stream with out_ready held high
        m_send({$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(0, 3)), first);
        last = first;
        for (int k = 1; k < 16; k++)
            m_send({$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(0, 3)), last);
        chk("throughput", 256'(last - first), 256'(15));
        m_drain();

        // Random backpressure including a 5-cycle stall
        lat_chk = 1'b0;
        d0 = deliv;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    m_if.out_ready = (k >= 10 && k < 15) ? 1'b0 : 1'($urandom() & 1);
                end
                @(negedge clk);
                m_if.out_ready = 1'b1;
            end
            begin
                int a;
                for (int k = 0; k < 10; k++)
                    m_send({$urandom(), $urandom(), $urandom(), $urandom()},
                           2'($urandom_range(0, 3)), a);
            end
        join
        m_drain();
        chk("bp_count", 256'(deliv - d0), 256'(10));
        lat_chk = 1'b1;

        // Reset with PIPE beats in flight
        m_send(r1, 2'b00, acc);
        m_send(r2, 2'b01, acc);
        m_rst = 1'b1;
        #2;
        chk("mid_rst_rdy", 256'(m_if.in_ready), 256'(0));
        @(negedge clk);
        m_rst = 1'b0;
        #2;
        chk("post_rst_vld", 256'(m_if.out_valid), 256'(0));
        chk("post_rst_dat", 256'(m_if.out_data), 256'(0));
        @(negedge clk);
        d0 = deliv;
        m_dir(128'(rep(32'h01010101, 4)), 2'b00, 128'(rep(32'h01010101, 4)));
        m_drain();
        chk("post_rst_count", 256'(deliv - d0), 256'(1));

        n = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_done", 256'(n < 5000), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
